// File: rtl/sar_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_scan_ctrl_pkg
// Description : Shared definitions for the multi-channel SAR scan controller:
//               scan FSM state encoding and default parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_scan_ctrl_pkg;

    // Default build of the controller: 8-bit, 4 channels, 2-clock sample
    localparam int NBITS_DEFAULT        = 8;
    localparam int NCH_DEFAULT          = 4;
    localparam int SAMPLE_CYC_DEFAULT   = 2;
    localparam int AVG_MAX_LOG2_DEFAULT = 3;

    // Scan sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_CONV   = 3'd2,
        ST_ACC    = 3'd3,
        ST_EMIT   = 3'd4
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/sar_scan_ctrl_bit_engine.sv
`default_nettype none
// ============================================================================
// Module      : sar_scan_ctrl_bit_engine
// Description : One NBITS successive-approximation binary search, MSB first.
//               A go pulse arms the search; each following clock drives one
//               trial code and keeps that bit if the comparator reports
//               Vin >= Vdac at the end of the cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_scan_ctrl_bit_engine #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             cmp_in,
    output logic [NBITS-1:0] dac_code,
    output logic [NBITS-1:0] code,
    output logic             done
);

    localparam logic [NBITS-1:0] MSB_ONEHOT = {1'b1, {(NBITS-1){1'b0}}};

    // trial holds the bits decided so far; bit_q is the one-hot bit under
    // test and doubles as the "search active" flag (all-zero when idle).
    logic [NBITS-1:0] trial;
    logic [NBITS-1:0] bit_q;
    logic             active;

    assign active = |bit_q;

    // Binary-search register: arm on go, then walk the test bit toward LSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trial <= '0;
            bit_q <= '0;
        end else if (go) begin
            trial <= '0;
            bit_q <= MSB_ONEHOT;
        end else if (active) begin
            if (cmp_in) begin
                trial <= trial | bit_q;
            end
            bit_q <= bit_q >> 1;
        end
    end

    // Trial code is only presented while a search is running
    assign dac_code = active ? (trial | bit_q) : '0;
    assign code     = trial;
    assign done     = bit_q[0];

endmodule
`default_nettype wire

// File: rtl/sar_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sar_scan_ctrl
// Description : Multi-channel successive-approximation scan controller.
//               Walks the captured channel mask in ascending order, runs
//               2^n sample+convert cycles per channel, averages them and
//               emits one result per channel. Optional continuous rescan.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_scan_ctrl
    import sar_scan_ctrl_pkg::*;
#(
    parameter  int NBITS        = NBITS_DEFAULT,
    parameter  int NCH          = NCH_DEFAULT,
    parameter  int SAMPLE_CYC   = SAMPLE_CYC_DEFAULT,
    parameter  int AVG_MAX_LOG2 = AVG_MAX_LOG2_DEFAULT,
    localparam int CHW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             cont,
    input  logic [NCH-1:0]   ch_mask,
    input  logic [2:0]       avg_log2,
    input  logic             cmp_in,
    output logic             sample,
    output logic [CHW-1:0]   ch_sel,
    output logic [NBITS-1:0] dac_code,
    output logic             busy,
    output logic             res_valid,
    output logic [NBITS-1:0] res_data,
    output logic [CHW-1:0]   res_ch
);

    localparam int         ACCW    = NBITS + AVG_MAX_LOG2;
    localparam int         CW      = AVG_MAX_LOG2 + 1;
    localparam int         PW      = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
    localparam logic [2:0] AVG_CAP = 3'(AVG_MAX_LOG2);
    localparam logic [PW-1:0] SAMPLE_LAST = PW'(SAMPLE_CYC - 1);

    scan_state_t      state;
    scan_state_t      state_n;

    logic [NCH-1:0]   mask_q;
    logic [2:0]       avg_q;
    logic [CHW-1:0]   ch_sel_q;
    logic [PW-1:0]    phase_cnt;
    logic [CW-1:0]    conv_cnt;
    logic [ACCW-1:0]  acc;

    logic [2:0]       avg_clamped;
    logic             mask_any;
    logic [CHW-1:0]   first_idx;
    logic             nxt_found;
    logic [CHW-1:0]   nxt_idx;
    logic             sample_last;
    logic             last_conv;
    logic             capture;

    logic             eng_go;
    logic             eng_done;
    logic [NBITS-1:0] eng_code;
    logic [NBITS-1:0] eng_dac;

    // ------------------------------------------------------------------------
    // Bit engine: one binary search per conversion
    // ------------------------------------------------------------------------
    sar_scan_ctrl_bit_engine #(
        .NBITS (NBITS)
    ) u_bit_engine (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .go       (eng_go),
        .cmp_in   (cmp_in),
        .dac_code (eng_dac),
        .code     (eng_code),
        .done     (eng_done)
    );

    // ------------------------------------------------------------------------
    // Capture-side helpers working on the live ch_mask / avg_log2 inputs
    // ------------------------------------------------------------------------
    assign avg_clamped = (avg_log2 > AVG_CAP) ? AVG_CAP : avg_log2;
    assign mask_any    = |ch_mask;

    // Lowest set bit of the live mask: first channel of a (re)scan
    always_comb begin
        first_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_idx = CHW'(i);
            end
        end
    end

    // Lowest set bit of the captured mask strictly above the current channel
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch_sel_q))) begin
                nxt_found = 1'b1;
                nxt_idx   = CHW'(i);
            end
        end
    end

    assign sample_last = (phase_cnt == SAMPLE_LAST);
    assign last_conv   = (conv_cnt == ((CW'(1) << avg_q) - CW'(1)));

    // ------------------------------------------------------------------------
    // Scan FSM state register
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode, bit-engine launch and busy flag
    always_comb begin
        state_n = state;
        eng_go  = 1'b0;
        capture = 1'b0;
        busy    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && mask_any) begin
                    capture = 1'b1;
                    state_n = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                busy = 1'b1;
                if (sample_last) begin
                    eng_go  = 1'b1;
                    state_n = ST_CONV;
                end
            end
            ST_CONV: begin
                busy = 1'b1;
                if (eng_done) begin
                    state_n = ST_ACC;
                end
            end
            ST_ACC: begin
                busy    = 1'b1;
                state_n = last_conv ? ST_EMIT : ST_SAMPLE;
            end
            ST_EMIT: begin
                if (nxt_found) begin
                    busy    = 1'b1;
                    state_n = ST_SAMPLE;
                end else if (cont) begin
                    // Rescan: take a fresh mask; an empty one ends the scan
                    capture = 1'b1;
                    busy    = mask_any;
                    state_n = mask_any ? ST_SAMPLE : ST_IDLE;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: captured settings, channel pointer, counters, accumulator
    // ------------------------------------------------------------------------
    // Mask / averaging exponent / channel pointer capture and advance
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mask_q   <= '0;
            avg_q    <= '0;
            ch_sel_q <= '0;
        end else if (capture) begin
            mask_q <= ch_mask;
            avg_q  <= avg_clamped;
            if (mask_any) begin
                ch_sel_q <= first_idx;
            end
        end else if ((state == ST_EMIT) && nxt_found) begin
            ch_sel_q <= nxt_idx;
        end
    end

    // Sample-phase timer: counts clocks with the sample switch closed
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            phase_cnt <= '0;
        end else if (state == ST_SAMPLE) begin
            phase_cnt <= sample_last ? '0 : phase_cnt + PW'(1);
        end else begin
            phase_cnt <= '0;
        end
    end

    // Conversion counter and accumulator for 2^n averaging
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            conv_cnt <= '0;
            acc      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    conv_cnt <= '0;
                    acc      <= '0;
                end
                ST_ACC: begin
                    acc      <= acc + ACCW'(eng_code);
                    conv_cnt <= last_conv ? '0 : conv_cnt + CW'(1);
                end
                ST_EMIT: begin
                    acc      <= '0;
                    conv_cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign sample    = (state == ST_SAMPLE);
    assign ch_sel    = ch_sel_q;
    assign dac_code  = eng_dac;
    assign res_valid = (state == ST_EMIT);
    assign res_data  = res_valid ? NBITS'(acc >> avg_q) : '0;
    assign res_ch    = res_valid ? ch_sel_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_sar_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_scan_ctrl
// Description : Scoreboard bench for sar_scan_ctrl (NBITS=8, NCH=4,
//               SAMPLE_CYC=2) with a behavioural comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cont;
    logic [3:0] ch_mask;
    logic [2:0] avg_log2;
    logic       cmp_in;
    logic       sample;
    logic [1:0] ch_sel;
    logic [7:0] dac_code;
    logic       busy;
    logic       res_valid;
    logic [7:0] res_data;
    logic [1:0] res_ch;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] vin [4];
    int         n_checks;
    int         n_fail;
    int         n_results;
    int         n_samples;
    logic       alt_en;
    logic       alt_phase;
    logic       chk_sel_en;
    logic       bad_sel;

    sar_scan_ctrl #(
        .NBITS        (8),
        .NCH          (4),
        .SAMPLE_CYC   (2),
        .AVG_MAX_LOG2 (3)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .start     (start),
        .cont      (cont),
        .ch_mask   (ch_mask),
        .avg_log2  (avg_log2),
        .cmp_in    (cmp_in),
        .sample    (sample),
        .ch_sel    (ch_sel),
        .dac_code  (dac_code),
        .busy      (busy),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ch    (res_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator: evaluated mid-cycle from the code currently on the DAC
    always @(negedge clk) cmp_in <= (vin[ch_sel] >= dac_code);

    // Per-conversion input alternation for the averaging test
    always @(posedge sample) begin
        n_samples = n_samples + 1;
        if (alt_en) begin
            vin[0]    = alt_phase ? 8'h43 : 8'h40;
            alt_phase = ~alt_phase;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result
    always @(negedge clk) begin
        exp_t e;
        if (res_valid) begin
            n_results = n_results + 1;
            if (exp_q.size() == 0) begin
                n_checks = n_checks + 1;
                n_fail   = n_fail + 1;
                $display("FAIL unexpected_result: got ch=%0d data=%0h, expected no result",
                         res_ch, res_data);
            end else begin
                e = exp_q.pop_front();
                check("res_ch", 32'(res_ch), 32'(e.ch));
                check("res_data", 32'(res_data), 32'(e.data));
            end
        end
        if (chk_sel_en && busy && ((ch_sel == 2'd0) || (ch_sel == 2'd2))) begin
            bad_sel = 1'b1;
        end
    end

    task automatic push_exp(input logic [1:0] ch, input logic [7:0] d);
        exp_t e;
        e.ch   = ch;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Start is sampled on the posedge between the two negedges
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!res_valid && (n < budget)) begin
            @(negedge clk);
            n = n + 1;
        end
        if (!res_valid) begin
            n_checks = n_checks + 1;
            n_fail   = n_fail + 1;
            $display("FAIL wait_valid_timeout: got no res_valid, expected one within %0d clocks", budget);
        end
    endtask

    task automatic wait_results(input int target, input int budget);
        int k;
        k = 0;
        while ((n_results < target) && (k < budget)) begin
            @(negedge clk);
            k = k + 1;
        end
        check("results_within_budget", 32'(n_results >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && (k < budget)) begin
            @(negedge clk);
            k = k + 1;
        end
        check("idle_within_budget", 32'(busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int base;
        n_checks   = 0;
        n_fail     = 0;
        n_results  = 0;
        n_samples  = 0;
        rst        = 1'b1;
        start      = 1'b0;
        cont       = 1'b0;
        ch_mask    = 4'b0000;
        avg_log2   = 3'd0;
        alt_en     = 1'b0;
        alt_phase  = 1'b0;
        chk_sel_en = 1'b0;
        bad_sel    = 1'b0;
        for (int i = 0; i < 4; i++) vin[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({sample, busy, res_valid, ch_sel, dac_code, res_data, res_ch}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outputs", 32'({sample, busy, res_valid, dac_code}), 32'd0);

        // 1: single channel, no averaging, latency 11 clocks
        ch_mask  = 4'b0001;
        avg_log2 = 3'd0;
        vin[0]   = 8'hA5;
        push_exp(2'd0, 8'hA5);
        pulse_start();
        wait_valid(200, lat);
        check("t1_latency", 32'(lat), 32'd11);
        check("t1_busy_with_result", 32'(busy), 32'd0);
        @(negedge clk);
        check("t1_idle_after", 32'({busy, sample, res_valid}), 32'd0);

        // 2: sparse mask, extreme inputs, skipped channels never selected
        ch_mask    = 4'b1010;
        vin[1]     = 8'h00;
        vin[3]     = 8'hFF;
        push_exp(2'd1, 8'h00);
        push_exp(2'd3, 8'hFF);
        base       = n_results;
        bad_sel    = 1'b0;
        chk_sel_en = 1'b1;
        pulse_start();
        wait_results(base + 2, 100);
        wait_idle(50);
        chk_sel_en = 1'b0;
        check("t2_skipped_channels", 32'(bad_sel), 32'd0);

        // 3: 4-way averaging of alternating 40/43 -> 41
        ch_mask   = 4'b0001;
        avg_log2  = 3'd2;
        alt_phase = 1'b0;
        alt_en    = 1'b1;
        n_samples = 0;
        push_exp(2'd0, 8'h41);
        pulse_start();
        wait_valid(300, lat);
        check("t3_latency", 32'(lat), 32'd44);
        check("t3_busy_with_result", 32'(busy), 32'd0);
        @(negedge clk);
        alt_en = 1'b0;
        check("t3_conversions", 32'(n_samples), 32'd4);

        // 4: continuous rescan, cont dropped after the third result
        avg_log2 = 3'd0;
        ch_mask  = 4'b0011;
        vin[0]   = 8'h12;
        vin[1]   = 8'h34;
        cont     = 1'b1;
        push_exp(2'd0, 8'h12);
        push_exp(2'd1, 8'h34);
        push_exp(2'd0, 8'h12);
        push_exp(2'd1, 8'h34);
        base = n_results;
        pulse_start();
        wait_results(base + 3, 200);
        cont = 1'b0;
        wait_results(base + 4, 100);
        wait_idle(50);
        repeat (30) @(negedge clk);
        check("t4_result_count", 32'(n_results - base), 32'd4);
        check("t4_idle", 32'(busy), 32'd0);

        // 5: empty mask ignored; start while busy ignored
        ch_mask = 4'b0000;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_mask0_busy", 32'(busy), 32'd0);
        end
        ch_mask = 4'b0001;
        vin[0]  = 8'h5A;
        vin[2]  = 8'h77;
        push_exp(2'd0, 8'h5A);
        base = n_results;
        pulse_start();
        repeat (3) @(negedge clk);
        ch_mask = 4'b0100;
        pulse_start();
        wait_valid(100, lat);
        check("t5_latency_unchanged", 32'(lat), 32'd6);
        wait_idle(50);
        repeat (20) @(negedge clk);
        check("t5_result_count", 32'(n_results - base), 32'd1);

        // 6: async reset during CONV bit 4, then a clean conversion
        ch_mask = 4'b0001;
        vin[0]  = 8'h99;
        base    = n_results;
        pulse_start();
        repeat (6) @(negedge clk);
        check("t6_dac_bit4", 32'(dac_code), 32'h98);
        rst = 1'b1;
        #1;
        check("t6_reset_outputs", 32'({sample, busy, res_valid, ch_sel, dac_code, res_data, res_ch}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_no_partial_result", 32'(n_results - base), 32'd0);
        vin[0] = 8'h3C;
        push_exp(2'd0, 8'h3C);
        pulse_start();
        wait_valid(200, lat);
        check("t6_latency_after_reset", 32'(lat), 32'd11);
        repeat (5) @(negedge clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
